// File: rtl/uart_tx_if.sv
// Byte push handshake between a producer and the UART transmitter FIFO.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready push into a small FIFO, LSB-first shift engine on txd.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    uart_tx_if.slave                    tx_if,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          bit_end;

    assign tx_if.tx_ready = (count != CW'(FIFO_DEPTH));
    assign push       = tx_if.tx_valid && tx_if.tx_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign bit_end    = (baud == BW'(CLKS_PER_BIT - 1));
    assign busy       = (state != IDLE) || (count != '0);
    assign fifo_count = count;

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_if.tx_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Shift engine; txd is registered so it only moves on bit boundaries.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            txd     <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        baud  <= '0;
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        txd     <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       txd;
    logic       busy;
    logic [3:0] fifo_count;
    int         total = 0;
    int         bad = 0;

    uart_tx_if tx_if ();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .tx_if      (tx_if),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of start-bit cycle 0; checks all 40 frame cycles, returns one cycle after stop.
    task automatic check_bits(input string tag, input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, i, c), 32'(txd), 32'(frame[i]));
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_start(input string tag, input int limit);
        int n = 0;
        while (txd !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(txd === 1'b0), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with tx_valid still high.
    task automatic push(input logic [7:0] b);
        int n = 0;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = b;
        while (tx_if.tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 32'(tx_if.tx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;

        // Reset values
        #12;
        chk("rst_txd",   32'(txd), 32'd1);
        chk("rst_ready", 32'(tx_if.tx_ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Idle line for 1000 cycles
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("idle_line", 32'({txd, busy, fifo_count}), 32'({1'b1, 1'b0, 4'd0}));
        end

        // Single byte 0x55
        push(8'h55);
        tx_if.tx_valid = 1'b0;
        chk("b55_pre_txd",   32'(txd), 32'd1);
        chk("b55_pre_count", 32'(fifo_count), 32'd1);
        chk("b55_pre_busy",  32'(busy), 32'd1);
        @(negedge clk);
        check_bits("b55", 8'h55);
        chk("b55_busy_after", 32'(busy), 32'd0);
        chk("b55_txd_after",  32'(txd), 32'd1);

        // 0x00 then 0xFF back-to-back, 5-cycle high gap
        push(8'h00);
        push(8'hFF);
        tx_if.tx_valid = 1'b0;
        check_bits("b00", 8'h00);
        chk("gap_idle", 32'(txd), 32'd1);
        @(negedge clk);
        check_bits("bff", 8'hFF);
        chk("bff_busy_after", 32'(busy), 32'd0);

        // Fill / backpressure with 0x01..0x0A
        fork
            begin
                bit seen_full = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    int n = 0;
                    tx_if.tx_valid = 1'b1;
                    tx_if.tx_data  = 8'(i + 1);
                    while (tx_if.tx_ready !== 1'b1 && n < 200) begin
                        if (!seen_full) begin
                            chk("full_count", 32'(fifo_count), 32'(DEPTH));
                            seen_full = 1'b1;
                        end
                        @(negedge clk);
                        n++;
                    end
                    chk("fill_ready", 32'(tx_if.tx_ready), 32'd1);
                    @(posedge clk);
                    @(negedge clk);
                end
                tx_if.tx_valid = 1'b0;
                chk("fill_saw_full", 32'(seen_full), 32'd1);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    wait_start($sformatf("fill%0d", i), 100);
                    check_bits($sformatf("fill%0d", i), 8'(i + 1));
                end
            end
        join
        chk("fill_busy_after",  32'(busy), 32'd0);
        chk("fill_count_after", 32'(fifo_count), 32'd0);

        // Simultaneous push and pop at count=1
        push(8'h11);
        push(8'h22);
        tx_if.tx_valid = 1'b0;
        chk("sim_count_a", 32'(fifo_count), 32'd1);
        check_bits("b11", 8'h11);
        chk("sim_pre_count", 32'(fifo_count), 32'd1);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h33;
        @(posedge clk);
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        chk("sim_post_count", 32'(fifo_count), 32'd1);
        check_bits("b22", 8'h22);
        chk("sim_idle_txd",  32'(txd), 32'd1);
        chk("sim_idle_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_bits("b33", 8'h33);
        chk("sim_busy_after", 32'(busy), 32'd0);

        // Reset during data bit 3 of 0xA5 with two bytes queued
        push(8'hA5);
        push(8'h01);
        push(8'h02);
        tx_if.tx_valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("mid_bit3_txd", 32'(txd), 32'd0);
        chk("mid_count",    32'(fifo_count), 32'd2);
        resetn = 1'b0;
        #1;
        chk("mid_rst_txd",   32'(txd), 32'd1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(tx_if.tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({txd, busy, fifo_count}), 32'({1'b1, 1'b0, 4'd0}));
        end
        push(8'h3C);
        tx_if.tx_valid = 1'b0;
        chk("b3c_pre_txd", 32'(txd), 32'd1);
        @(negedge clk);
        check_bits("b3c", 8'h3C);
        for (int i = 0; i < 100; i++) begin
            chk("b3c_no_more", 32'({txd, busy, fifo_count}), 32'({1'b1, 1'b0, 4'd0}));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter that drives the SoC TXD pin.
- Complements the SoC's existing RXD side.
- CPU or other bus logic pushes bytes through a valid/ready handshake into a small internal FIFO.
- A baud-timed shift engine serialises each byte LSB-first: one start bit, eight data bits, one stop bit.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 8, byte entries in the transmit FIFO; must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid this cycle.
- tx_ready  output  1  FIFO can accept a byte this cycle (= not full).
- txd  output  1  serial line; idle high.
- busy  output  1  FIFO non-empty or frame in progress.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently in FIFO (not counting the byte being shifted).

Behaviour:
- Reset (async, resetn=0): txd=1, tx_ready=1, busy=0, fifo_count=0.
  - FIFO pointers cleared, FSM=IDLE, baud counter=0, bit index=0.
  - Reset mid-frame aborts the frame immediately; txd returns high asynchronously; queued bytes are discarded.
- Push handshake: a byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - While tx_ready=0, tx_valid is ignored; the producer holds tx_data/tx_valid until accepted.
  - Exactly one FIFO entry per accepting edge; no duplication or loss.
- Pop: occurs on an edge where FSM=IDLE and fifo_count != 0.
  - A byte pushed on edge N is at earliest popped on edge N+1.
- Simultaneous push and pop on the same edge: both occur; fifo_count unchanged.
  - When full, push is refused that edge even if a pop happens; the freed slot shows tx_ready=1 the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- FSM states:
  - IDLE: txd=1. On pop, load shift register with the byte, clear baud counter, go to START.
  - START: txd=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment bit index; after bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- txd is registered (glitch-free); it changes only on state/bit boundaries.
- The first start-bit cycle is the cycle after the pop edge.
- Frame length: 10*CLKS_PER_BIT cycles from first start-bit cycle to end of stop bit.
- Back-to-back: IDLE lasts one cycle between frames when FIFO is non-empty.
  - Stop level is therefore CLKS_PER_BIT+1 cycles; frame period is 10*CLKS_PER_BIT+1.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary; width $clog2(CLKS_PER_BIT).
- busy = (FSM != IDLE) || (fifo_count != 0), registered-state derived; busy=0 only when the line is idle and nothing is queued.

Test Plan:
- Single byte (CLKS_PER_BIT=4): push 0x55 once → one cycle later txd=0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy falls after stop; total 40 cycles low-to-stop-end.
- Extremes: push 0x00 then 0xFF back-to-back → first frame's data bits all 0, second's all 1; stop-to-start high gap is exactly 5 cycles (CLKS_PER_BIT+1).
- Fill/backpressure: hold tx_valid with bytes 0x01..0x0A continuously (FIFO_DEPTH=8, line stalled during fill) → tx_ready drops when fifo_count=8; all 10 bytes appear on txd in order 0x01..0x0A, none duplicated.
- Simultaneous push/pop: push on the same edge the FSM pops from a count=1 FIFO → fifo_count stays 1; both bytes transmitted in order.
- Reset mid-frame: assert resetn=0 during DATA bit 3 of 0xA5 with 2 bytes queued → txd=1, fifo_count=0, busy=0, tx_ready=1 immediately. After release, push 0x3C → a clean 0x3C frame only.
- Idle line: no pushes for 1000 cycles after reset → txd constantly 1, busy=0, fifo_count=0.
